// File: rtl/four_switch_debouncer.sv
// Four-channel switch debouncer: 2-flop sync + stability counter per bit.
// Ports: clk, rst_n, sw_in[3:0] -> sw_out[3:0], rise, fall, any_change.
module four_switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_in,
  output logic [3:0] sw_out,
  output logic [3:0] rise,
  output logic [3:0] fall,
  output logic       any_change
);

  localparam logic [CNT_WIDTH-1:0] LP_TERM =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LP_ONE =
    CNT_WIDTH'(1);

  logic [3:0]           r_sync1;
  logic [3:0]           r_sync2;
  logic [3:0]           r_sw_out;
  logic [3:0]           r_rise;
  logic [3:0]           r_fall;
  logic                 r_any;
  logic [CNT_WIDTH-1:0] r_cnt [4];

  logic [3:0] w_diff;
  logic [3:0] w_term;
  logic [3:0] w_fire;

  // A bit is "counting" whenever its synced input disagrees
  // with the debounced level; agreement means idle.
  assign w_diff = r_sync2 ^ r_sw_out;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_term
      assign w_term[gi] = (r_cnt[gi] == LP_TERM);
    end
  endgenerate

  assign w_fire = w_diff & w_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
    end
  end

  // Counter clears on any agreement (bounce restarts the
  // window) and on qualification, so it stays below D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_diff[i] && !w_term[i]) begin
          r_cnt[i] <= r_cnt[i] + LP_ONE;
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Pulses are registered on the same edge as the level
  // update, so they line up with the new sw_out value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_out <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_any    <= 1'b0;
    end else begin
      r_sw_out <= (r_sw_out & ~w_fire)
                | (r_sync2 & w_fire);
      r_rise   <= w_fire & r_sync2;
      r_fall   <= w_fire & ~r_sync2;
      r_any    <= |w_fire;
    end
  end

  assign sw_out     = r_sw_out;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign any_change = r_any;

endmodule

// File: tb/tb_four_switch_debouncer.sv
// Bench for four_switch_debouncer with D=4, CNT_WIDTH=4.
// Directed scenarios plus random toggling against a window model.
module tb_four_switch_debouncer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_in = 4'hF;
  logic [3:0] sw_out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any_change;

  four_switch_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_in(sw_in),
    .sw_out(sw_out),
    .rise(rise),
    .fall(fall),
    .any_change(any_change)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ecnt = 0;
  int pulses;
  int pedge;
  int last_tr;

  // win[j] = raw input sampled j edges before the newest one
  logic [3:0] win [0:D+1];
  logic [3:0] m_out;
  logic [3:0] m_rise;
  logic [3:0] m_fall;
  logic       m_any;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j <= D + 1; j++) win[j] = 4'h0;
    m_out  = 4'h0;
    m_rise = 4'h0;
    m_fall = 4'h0;
    m_any  = 1'b0;
  endtask

  // Output flips to v at edge k when the D raw samples taken
  // at edges k-D-1 .. k-2 all equal v (2 sync flops of delay).
  task automatic step();
    logic [3:0] s;
    logic [3:0] nout;
    logic       all;
    s = sw_in;
    @(posedge clk);
    ecnt++;
    if (!rst_n) begin
      model_clear();
    end else begin
      nout = m_out;
      for (int b = 0; b < 4; b++) begin
        all = 1'b1;
        for (int j = 1; j <= D; j++)
          if (win[j][b] == m_out[b]) all = 1'b0;
        if (all) nout[b] = ~m_out[b];
      end
      for (int j = D + 1; j > 0; j--) win[j] = win[j-1];
      win[0] = s;
      m_rise = nout & ~m_out;
      m_fall = m_out & ~nout;
      m_any  = |(m_rise | m_fall);
      m_out  = nout;
    end
    #1;
    chk("sw_out", 16'(sw_out), 16'(m_out));
    chk("rise", 16'(rise), 16'(m_rise));
    chk("fall", 16'(fall), 16'(m_fall));
    chk("any", 16'(any_change), 16'(m_any));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"}, 16'(sw_out), 16'h0);
    chk({tag, "_rise"}, 16'(rise), 16'h0);
    chk({tag, "_fall"}, 16'(fall), 16'h0);
    chk({tag, "_any"}, 16'(any_change), 16'h0);
    chk({tag, "_cnt"},
        {dut.r_cnt[3], dut.r_cnt[2],
         dut.r_cnt[1], dut.r_cnt[0]}, 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    chk_zero("async_rst");
  endtask

  initial begin
    model_clear();
    // Reset and power-up
    step();
    step();
    chk_zero("por");
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (any_change) pulses++;
      if (k == 5) chk("pwr_e5", 16'(sw_out), 16'h0);
      if (k == 6) begin
        chk("pwr_e6_out", 16'(sw_out), 16'hF);
        chk("pwr_e6_rise", 16'(rise), 16'hF);
      end
    end
    chk("pwr_pulses", 16'(pulses), 16'd1);

    // Back to all-low, then glitch rejection on bit 0
    sw_in = 4'h0;
    repeat (8) step();
    pulses = 0;
    sw_in = 4'h1;
    repeat (3) step();
    sw_in = 4'h0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (any_change) pulses++;
    end
    chk("glitch_out", 16'(sw_out), 16'h0);
    chk("glitch_pulses", 16'(pulses), 16'd0);
    chk("glitch_cnt", 16'(dut.r_cnt[0]), 16'h0);

    // Fall detection from 0101
    sw_in = 4'b0101;
    repeat (8) step();
    chk("fall_pre", 16'(sw_out), 16'h5);
    sw_in = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 6) begin
        chk("fall_e6_out", 16'(sw_out), 16'h1);
        chk("fall_e6_fall", 16'(fall), 16'h4);
        chk("fall_e6_rise", 16'(rise), 16'h0);
      end
    end

    // Staggered bits 1 and 3
    pulses = 0;
    sw_in = 4'b0011;
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) sw_in = 4'b1011;
      step();
      if (any_change) pulses++;
      if (k == 6) begin
        chk("stag_e6_out", 16'(sw_out), 16'h3);
        chk("stag_e6_rise", 16'(rise), 16'h2);
      end
      if (k == 8) begin
        chk("stag_e8_out", 16'(sw_out), 16'hB);
        chk("stag_e8_rise", 16'(rise), 16'h8);
      end
    end
    chk("stag_pulses", 16'(pulses), 16'd2);

    // Bounce on bit 2, then hold high
    pulses = 0;
    pedge = 0;
    last_tr = 0;
    for (int t = 0; t < 18; t++) begin
      if (t < 10) begin
        if (((t / 2) % 2 == 0) != sw_in[2])
          last_tr = ecnt + 1;
        sw_in[2] = ((t / 2) % 2 == 0);
      end
      step();
      if (rise[2]) begin
        pulses++;
        pedge = ecnt;
      end
    end
    chk("bounce_pulses", 16'(pulses), 16'd1);
    chk("bounce_edge", 16'(pedge - last_tr), 16'd5);
    chk("bounce_out", 16'(sw_out), 16'hF);

    // Reset in the middle of a count
    sw_in = 4'h0;
    repeat (8) step();
    sw_in = 4'h1;
    repeat (4) step();
    chk("mid_cnt2", 16'(dut.r_cnt[0]), 16'd2);
    do_reset();
    step();
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (rise[0]) pulses++;
      if (k == 5) chk("mid_e5", 16'(sw_out), 16'h0);
      if (k == 6) chk("mid_e6", 16'(sw_out), 16'h1);
    end
    chk("mid_pulses", 16'(pulses), 16'd1);

    // Random toggling with random hold times
    repeat (80) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 2) == 0)
          sw_in[b] = ~sw_in[b];
      repeat ($urandom_range(1, 7)) step();
    end
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/four_switch_debouncer.md
# four_switch_debouncer

Conditions four raw, asynchronous, bouncing slide-switch/push-button inputs into clean, synchronous, debounced levels for the combinational gate stage. Its four `sw_out` bits drive the gate's `a`, `b`, `c` and `d` inputs directly. It also emits one-cycle rise, fall and any-change pulses for edge-triggered logic such as counters and LED latches. Each bit is debounced independently by its own synchronizer and stability counter.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive clock cycles a synchronized input must differ from `sw_out` before `sw_out` updates. Legal range is 1 to 2^`CNT_WIDTH`−1.
- `CNT_WIDTH`, default 16: width of each per-bit stability counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `sw_in`  in  4  raw switch inputs, asynchronous to `clk`.
- `sw_out`  out  4  debounced levels; bit i feeds gate input a/b/c/d for i = 0/1/2/3.
- `rise`  out  4  one-cycle pulse on bit i when `sw_out[i]` goes 0→1.
- `fall`  out  4  one-cycle pulse on bit i when `sw_out[i]` goes 1→0.
- `any_change`  out  1  one-cycle pulse, equal to OR of all `rise` and `fall` bits in the same cycle.

## Operation
- **Synchronizer:** per bit, a 2-flop chain `sync1[i]` → `sync2[i]`. Reset value is 0.
- **Per-bit FSM, IDLE:** entered when `sync2[i]` == `sw_out[i]`.
  - Counter `cnt[i]` is held at 0.
- **Per-bit FSM, COUNTING:** entered when `sync2[i]` != `sw_out[i]`.
  - If `cnt[i]` == `DEBOUNCE_CYCLES`−1 at the edge: `sw_out[i]` <= `sync2[i]`, `cnt[i]` <= 0, and the `rise[i]` or `fall[i]` pulse asserts.
  - Otherwise `cnt[i]` <= `cnt[i]`+1.
- **COUNTING → IDLE (glitch or bounce):** if `sync2[i]` returns to equal `sw_out[i]` before the terminal count, then `cnt[i]` <= 0. No output change and no pulse.
- **Counter width:** the counter never exceeds `DEBOUNCE_CYCLES`−1, so it never wraps.
- **Bit independence:** bits are fully independent. Simultaneous qualification of several bits updates them in the same cycle, with multiple `rise`/`fall` bits set together and a single `any_change` pulse.
- **Pulse outputs:** `rise`, `fall` and `any_change` are registered. They are high only in the cycle immediately following the `sw_out` update edge, i.e. coincident with the new `sw_out` value, and return to 0 on the next edge.
- **Reset:** asserting `rst_n` low clears, immediately and asynchronously, `sync1`, `sync2`, `cnt`, `sw_out`, `rise`, `fall` and `any_change` to 0.
- **Reset mid-count:** any count in progress is discarded. After release, a held-high input is re-qualified from count 0 and produces a `rise` pulse.

## Timing
- **Edge numbering:** E1 is the first rising edge that samples a new stable `sw_in[i]` value.
  - `sync1` updates at E1.
  - `sync2` updates at E2.
  - The counter increments at E3 … E(D+1).
  - `sw_out[i]` and the pulse update at E(D+2), where D = `DEBOUNCE_CYCLES`.
- **Total latency:** D+2 edges from the first sampling edge to output change. With D=1, the latency is 3 edges.
- **Glitch rejection:** any input pulse or bounce whose synchronized width is < D cycles produces no output change.
- **Bounce timing:** with bounce, the D-cycle window restarts at the last transition.
- **Reset release:** reset deassertion is taken as synchronous to `clk` by the top level. Outputs remain 0 until a qualified change occurs, at the earliest D+2 edges after release.
- **Combinational paths:** there is no combinational path from `sw_in` to any output.

## Test plan
All scenarios use D=4 and `CNT_WIDTH`=4.
- **Reset and power-up:**
  - Stimulus: `rst_n`=0 with `sw_in`=4'hF.
  - Required: `sw_out`=0, `rise`=`fall`=0, `any_change`=0.
  - Stimulus: release reset, hold `sw_in`=4'hF.
  - Required: `sw_out`=4'hF at E6; `rise`=4'hF and `any_change`=1 for exactly one cycle.
- **Glitch rejection:**
  - Stimulus: `sw_in[0]` high for 3 cycles, then low.
  - Required: `sw_out` stays 0, no pulses, `cnt[0]` back at 0.
- **Fall detection:**
  - Stimulus: from `sw_out`=4'b0101, drive `sw_in`=4'b0001.
  - Required: `sw_out`=4'b0001 at E6; `fall`=4'b0100 and `rise`=0 for one cycle.
- **Staggered bits:**
  - Stimulus: raise bit1 at cycle 0 and bit3 at cycle 2.
  - Required: `sw_out[1]` rises at E6 and `sw_out[3]` at E8, with two separate one-cycle `any_change` pulses.
- **Bounce:**
  - Stimulus: toggle bit2 every 2 cycles for 10 cycles, then hold high.
  - Required: exactly one `rise[2]` pulse, occurring 6 edges after the final transition.
- **Reset mid-count:**
  - Stimulus: raise bit0 and pull `rst_n` low when `cnt[0]`=2.
  - Required: all outputs and counters are 0 immediately.
  - Stimulus: release reset with bit0 still high.
  - Required: `sw_out[0]` rises at E6 after release and `rise[0]` pulses once.
